// File: rtl/instr_fetch_window_pkg.sv
// ============================================================================
//  Module   : instr_fetch_window_pkg
//  Brief    : Shared sizes and FSM state encoding for the instruction fetch
//             window. Optional macro: IFW_OOB_TRAP_EN adds the TRAP state.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_window_pkg;

  localparam int DEPTH   = 256;  // bytes of instruction storage
  localparam int ADDR_W  = 8;    // log2(DEPTH)
  localparam int RD_WIN  = 8;    // bytes presented per fetch window
  localparam int WR_WIN  = 4;    // max bytes per load beat
  localparam int SHIFT_W = 3;    // log2(RD_WIN)
  localparam int LDCNT_W = 2;    // log2(WR_WIN)
  localparam int PW      = ADDR_W + 1;  // pointer width able to hold DEPTH

  // Fetch FSM states; TRAP only exists when bounds checking is built in
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2
`ifdef IFW_OOB_TRAP_EN
    ,
    ST_TRAP  = 2'd3
`endif
  } ifw_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_window_if.sv
// ============================================================================
//  Module   : instr_fetch_window_if
//  Brief    : Loader, consumer and window signals of the fetch window block.
//             master = loader/decoder side, slave = fetch window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_window_if;
  import instr_fetch_window_pkg::*;

  logic                  ld_clr;
  logic                  ld_vld;
  logic                  ld_rdy;
  logic [WR_WIN*8-1:0]   ld_data;
  logic [LDCNT_W-1:0]    ld_cnt_m1;
  logic                  ld_last;
  logic                  hlt;
  logic                  shift_vld;
  logic [SHIFT_W-1:0]    shift_m1;
  logic                  jump_en;
  logic [ADDR_W-1:0]     jump_addr;
  logic [RD_WIN*8-1:0]   win_data;
  logic                  win_vld;
  logic [ADDR_W-1:0]     rd_ptr_out;
  logic [ADDR_W:0]       wr_ptr_out;
  logic                  oob_trap;

  modport master (
    output ld_clr, ld_vld, ld_data, ld_cnt_m1, ld_last,
    output hlt, shift_vld, shift_m1, jump_en, jump_addr,
    input  ld_rdy, win_data, win_vld, rd_ptr_out, wr_ptr_out, oob_trap
  );

  modport slave (
    input  ld_clr, ld_vld, ld_data, ld_cnt_m1, ld_last,
    input  hlt, shift_vld, shift_m1, jump_en, jump_addr,
    output ld_rdy, win_data, win_vld, rd_ptr_out, wr_ptr_out, oob_trap
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_window_byte_ram.sv
// ============================================================================
//  Module   : ifw_byte_ram
//  Brief    : DEPTH x 8 byte store with a WR_WIN-lane masked write port and
//             an RD_WIN-lane registered read port. Read lanes whose mask bit
//             is clear return 8'h00. Addresses wrap modulo DEPTH.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifw_byte_ram
  import instr_fetch_window_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_we,
  input  wire logic [ADDR_W-1:0]     i_waddr,
  input  wire logic [WR_WIN*8-1:0]   i_wdata,
  input  wire logic [WR_WIN-1:0]     i_wmask,
  input  wire logic [ADDR_W-1:0]     i_raddr,
  input  wire logic [RD_WIN-1:0]     i_rmask,
  output logic      [RD_WIN*8-1:0]   o_rdata
);

  logic [7:0]          mem_q [DEPTH];
  logic [RD_WIN*8-1:0] rdata_q;
  logic [RD_WIN*8-1:0] rdata_d;

  // Gather the window lanes; bytes outside the loaded range read as zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < RD_WIN; i++) begin
      if (i_rmask[i]) begin
        rdata_d[8*i +: 8] = mem_q[i_raddr + ADDR_W'(i)];
      end
    end
  end

  // Byte-lane masked write of one load beat
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < WR_WIN; i++) begin
        if (i_wmask[i]) begin
          mem_q[i_waddr + ADDR_W'(i)] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read: window appears one cycle after its address
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_window.sv
// ============================================================================
//  Module   : instr_fetch_window
//  Brief    : Instruction byte store with loader write port and registered,
//             handshaked RD_WIN-byte fetch window (shift / jump / halt).
//             Optional macro: IFW_OOB_TRAP_EN enables a sticky out-of-bounds
//             fetch trap; without it pointers wrap modulo DEPTH.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_window
  import instr_fetch_window_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  instr_fetch_window_if.slave   bus
);

  localparam logic [ADDR_W:0] C_DEPTH_EXT = PW'(DEPTH);

  ifw_state_e          state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                ld_done_q, ld_done_d;
  logic                win_vld_q, win_vld_d;

  logic                w_ld_rdy;
  logic                w_ld_fire;
  logic [WR_WIN-1:0]   w_ld_mask;
  logic                w_do_shift;
  logic                w_do_jump;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_next;
  logic [ADDR_W-1:0]   w_byte_addr [RD_WIN];
  logic [RD_WIN-1:0]   w_byte_ok;
  logic                w_avail;

  // Loader accepts while not finished and a full beat still fits
  assign w_ld_rdy  = ~ld_done_q & ((C_DEPTH_EXT - wr_ptr_q) >= PW'(WR_WIN));
  // A clear in the same cycle drops the beat
  assign w_ld_fire = bus.ld_vld & w_ld_rdy & ~bus.ld_clr;

  for (genvar g = 0; g < WR_WIN; g++) begin : g_ld_lane
    assign w_ld_mask[g] = (LDCNT_W'(g) <= bus.ld_cnt_m1);
  end

  // Halt freezes the pointer; a shift only counts against a valid window
  assign w_do_shift = bus.shift_vld & win_vld_q & ~bus.hlt;
  assign w_do_jump  = bus.jump_en & ~bus.shift_vld & ~bus.hlt;
  assign w_base     = bus.jump_en ? bus.jump_addr : rd_ptr_q;

`ifdef IFW_OOB_TRAP_EN
  logic [ADDR_W:0] w_next_full;
  logic            w_oob;
  logic            oob_q, oob_d;

  // Next pointer kept one bit wider so overruns past DEPTH are visible
  always_comb begin
    w_next_full = PW'(rd_ptr_q);
    if (w_do_shift) begin
      w_next_full = PW'(w_base) + PW'(bus.shift_m1) + PW'(1);
    end else if (w_do_jump) begin
      w_next_full = PW'(bus.jump_addr);
    end
  end

  assign w_next = w_next_full[ADDR_W-1:0];
  assign w_oob  = (w_next_full >= C_DEPTH_EXT)
                | (ld_done_q & (w_next_full > wr_ptr_q))
                | (ld_done_q & bus.jump_en & (w_do_shift | w_do_jump)
                   & (PW'(bus.jump_addr) >= wr_ptr_q));
`else
  // Next pointer wraps modulo DEPTH
  always_comb begin
    w_next = rd_ptr_q;
    if (w_do_shift) begin
      w_next = w_base + ADDR_W'(bus.shift_m1) + ADDR_W'(1);
    end else if (w_do_jump) begin
      w_next = bus.jump_addr;
    end
  end
`endif

  // Per-byte "already loaded" test of the candidate window; uses the
  // registered wr_ptr so bytes landing this cycle count from the next one
  always_comb begin
    for (int i = 0; i < RD_WIN; i++) begin
      w_byte_addr[i] = w_next + ADDR_W'(i);
      w_byte_ok[i]   = ({1'b0, w_byte_addr[i]} < wr_ptr_q);
    end
  end

  assign w_avail = ld_done_q | (&w_byte_ok);

  // Next-state: load pointer, fetch pointer and EMPTY/WAIT/FETCH(/TRAP)
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ld_done_d = ld_done_q;
`ifdef IFW_OOB_TRAP_EN
    oob_d     = oob_q;
`endif
    if (bus.ld_clr) begin
      state_d   = ST_EMPTY;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ld_done_d = 1'b0;
`ifdef IFW_OOB_TRAP_EN
      oob_d     = 1'b0;
`endif
    end else begin
      if (w_ld_fire) begin
        wr_ptr_d  = wr_ptr_q + PW'(bus.ld_cnt_m1) + PW'(1);
        ld_done_d = ld_done_q | bus.ld_last;
      end
      case (state_q)
        ST_EMPTY: begin
          if ((wr_ptr_q != '0) || ld_done_q) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT, ST_FETCH: begin
`ifdef IFW_OOB_TRAP_EN
          if (w_oob) begin
            state_d = ST_TRAP;
            oob_d   = 1'b1;
          end else
`endif
          begin
            rd_ptr_d = w_next;
            state_d  = w_avail ? ST_FETCH : ST_WAIT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    win_vld_d = (state_d == ST_FETCH);
  end

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ld_done_q <= 1'b0;
      win_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ld_done_q <= ld_done_d;
      win_vld_q <= win_vld_d;
    end
  end

`ifdef IFW_OOB_TRAP_EN
  // Sticky trap flag, cleared only by reset or load restart
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
    end
  end
  assign bus.oob_trap = oob_q;
`else
  assign bus.oob_trap = 1'b0;
`endif

  ifw_byte_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ld_fire & ~rst),
    .i_waddr (wr_ptr_q[ADDR_W-1:0]),
    .i_wdata (bus.ld_data),
    .i_wmask (w_ld_mask),
    .i_raddr (w_next),
    .i_rmask (w_byte_ok),
    .o_rdata (bus.win_data)
  );

  assign bus.ld_rdy     = w_ld_rdy;
  assign bus.win_vld    = win_vld_q;
  assign bus.rd_ptr_out = rd_ptr_q;
  assign bus.wr_ptr_out = wr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_window.sv
// ============================================================================
//  Module   : tb_instr_fetch_window
//  Brief    : Self-checking bench for instr_fetch_window: table of consumer
//             vectors with a scoreboard queue plus hand-written load, clear,
//             reset and (IFW_OOB_TRAP_EN) trap sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_window;
  import instr_fetch_window_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_window_if bus ();

  instr_fetch_window dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic             shift_vld;
    logic [2:0]       shift_m1;
    logic             hlt;
    logic             jump_en;
    logic [7:0]       jump_addr;
    logic [7:0]       exp_rd;
    logic             exp_vld;
  } vec_t;

  typedef struct {
    logic [7:0]  rd;
    logic        vld;
    logic [63:0] win;
  } exp_t;

  vec_t vecs [$];
  exp_t sbq  [$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference byte image of what has been loaded
  logic [7:0] ref_mem [DEPTH];
  int         ref_wr   = 0;
  bit         ref_done = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_win(input int p);
    logic [63:0] w;
    int a;
    w = '0;
    for (int i = 0; i < RD_WIN; i++) begin
      a = (p + i) % DEPTH;
      if (a < ref_wr) w[8*i +: 8] = ref_mem[a];
    end
    return w;
  endfunction

  task automatic idle();
    bus.ld_clr    = 1'b0;
    bus.ld_vld    = 1'b0;
    bus.ld_data   = '0;
    bus.ld_cnt_m1 = '0;
    bus.ld_last   = 1'b0;
    bus.hlt       = 1'b0;
    bus.shift_vld = 1'b0;
    bus.shift_m1  = '0;
    bus.jump_en   = 1'b0;
    bus.jump_addr = '0;
  endtask

  task automatic ref_clear();
    ref_wr   = 0;
    ref_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ld_rdy"},   bus.ld_rdy,     1);
    check({tag, "_win_vld"},  bus.win_vld,    0);
    check({tag, "_win_data"}, bus.win_data,   0);
    check({tag, "_rd_ptr"},   bus.rd_ptr_out, 0);
    check({tag, "_wr_ptr"},   bus.wr_ptr_out, 0);
    check({tag, "_oob"},      bus.oob_trap,   0);
  endtask

  task automatic load_beat(input logic [31:0] data, input int cnt, input logic last);
    bit acc;
    acc = !ref_done && ((DEPTH - ref_wr) >= WR_WIN);
    bus.ld_vld    = 1'b1;
    bus.ld_data   = data;
    bus.ld_cnt_m1 = LDCNT_W'(cnt - 1);
    bus.ld_last   = last;
    check("ld_rdy_beat", bus.ld_rdy, acc);
    tick();
    if (acc) begin
      for (int i = 0; i < cnt; i++) ref_mem[(ref_wr + i) % DEPTH] = data[8*i +: 8];
      ref_wr   = ref_wr + cnt;
      ref_done = ref_done | last;
    end
    bus.ld_vld  = 1'b0;
    bus.ld_last = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    int k;
    k = 0;
    while (bus.win_vld !== 1'b1 && k < 16) begin
      tick();
      k++;
    end
    n_vec++;
    if (bus.win_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: win_vld=%b after %0d cycles, expected 1", name, bus.win_vld, k);
    end
  endtask

  task automatic add_vec(input logic sv, input logic [2:0] m1, input logic h, input logic je,
                         input logic [7:0] ja, input logic [7:0] erd, input logic evld);
    vec_t v;
    v = '{sv, m1, h, je, ja, erd, evld};
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Load 0x00..0x09 as beats of 4,4,2 (last)
    load_beat(32'h0302_0100, 4, 1'b0);
    load_beat(32'h0706_0504, 4, 1'b0);
    load_beat(32'h0000_0908, 2, 1'b1);
    wait_vld("first_fetch_vld");
    check("first_win",    bus.win_data,   exp_win(0));
    check("first_rd",     bus.rd_ptr_out, 0);
    check("first_wr",     bus.wr_ptr_out, 10);
    check("done_ld_rdy",  bus.ld_rdy,     0);

    // Consumer vectors, applied back to back
    add_vec(1, 3'd2, 0, 0, 8'h00, 8'd3,  1);
    add_vec(1, 3'd2, 0, 0, 8'h00, 8'd6,  1);
    add_vec(1, 3'd2, 0, 0, 8'h00, 8'd9,  1);
    add_vec(0, 3'd0, 0, 0, 8'h00, 8'd9,  1);
    add_vec(1, 3'd2, 1, 0, 8'h00, 8'd9,  1);
    add_vec(0, 3'd0, 0, 1, 8'h02, 8'd2,  1);
    add_vec(1, 3'd1, 0, 1, 8'h04, 8'd6,  1);
`ifndef IFW_OOB_TRAP_EN
    add_vec(1, 3'd1, 0, 1, 8'h20, 8'h22, 1);
    add_vec(1, 3'd1, 1, 1, 8'h40, 8'h22, 1);
    add_vec(1, 3'd7, 0, 0, 8'h00, 8'h2A, 1);
    add_vec(1, 3'd7, 0, 1, 8'hFC, 8'h04, 1);
`endif
    foreach (vecs[k]) begin
      bus.shift_vld = vecs[k].shift_vld;
      bus.shift_m1  = vecs[k].shift_m1;
      bus.hlt       = vecs[k].hlt;
      bus.jump_en   = vecs[k].jump_en;
      bus.jump_addr = vecs[k].jump_addr;
      e.rd  = vecs[k].exp_rd;
      e.vld = vecs[k].exp_vld;
      e.win = exp_win(int'(vecs[k].exp_rd));
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      check($sformatf("vec%0d_rd",  k), bus.rd_ptr_out, e.rd);
      check($sformatf("vec%0d_vld", k), bus.win_vld,    e.vld);
      check($sformatf("vec%0d_win", k), bus.win_data,   e.win);
    end
    idle();

    // Clear with a simultaneous beat: the beat must be dropped
    bus.ld_clr    = 1'b1;
    bus.ld_vld    = 1'b1;
    bus.ld_data   = 32'hEEEE_EEEE;
    bus.ld_cnt_m1 = 2'd3;
    tick();
    idle();
    ref_clear();
    check("clr_wr",     bus.wr_ptr_out, 0);
    check("clr_rd",     bus.rd_ptr_out, 0);
    check("clr_vld",    bus.win_vld,    0);
    check("clr_ld_rdy", bus.ld_rdy,     1);

    // Partial load without ld_last stays in WAIT until a full window exists
    load_beat(32'hA3A2_A1A0, 4, 1'b0);
    load_beat(32'h0000_A5A4, 2, 1'b0);
    tick();
    tick();
    check("wait6_vld", bus.win_vld,    0);
    check("wait6_wr",  bus.wr_ptr_out, 6);
    load_beat(32'h0000_A7A6, 2, 1'b0);
    check("wait8_vld_same_cycle", bus.win_vld, 0);
    tick();
    check("wait8_vld", bus.win_vld,  1);
    check("wait8_win", bus.win_data, exp_win(0));

    // Reset in the middle of a load beat
    bus.ld_vld    = 1'b1;
    bus.ld_data   = 32'h1111_1111;
    bus.ld_cnt_m1 = 2'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    ref_clear();
    check_reset_vals("rst_load");

    // Reset in the middle of fetching
    load_beat(32'h1312_1110, 4, 1'b0);
    load_beat(32'h1716_1514, 4, 1'b1);
    wait_vld("rst_fetch_pre_vld");
    bus.shift_vld = 1'b1;
    bus.shift_m1  = 3'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    ref_clear();
    check_reset_vals("rst_fetch");

    // 16 bytes loaded and done, then a jump well past the end
    load_beat(32'h2322_2120, 4, 1'b0);
    load_beat(32'h2726_2524, 4, 1'b0);
    load_beat(32'h2B2A_2928, 4, 1'b0);
    load_beat(32'h2F2E_2D2C, 4, 1'b1);
    wait_vld("oob_pre_vld");
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h40;
    tick();
    idle();
`ifdef IFW_OOB_TRAP_EN
    check("oob_trap_set", bus.oob_trap, 1);
    check("oob_vld",      bus.win_vld,  0);
    tick();
    check("oob_sticky",   bus.oob_trap, 1);
`else
    check("far_jump_oob", bus.oob_trap,   0);
    check("far_jump_rd",  bus.rd_ptr_out, 8'h40);
    check("far_jump_vld", bus.win_vld,    1);
    check("far_jump_win", bus.win_data,   exp_win(8'h40));
`endif
    bus.ld_clr = 1'b1;
    tick();
    idle();
    ref_clear();
    check("final_clr_oob", bus.oob_trap,   0);
    check("final_clr_vld", bus.win_vld,    0);
    check("final_clr_wr",  bus.wr_ptr_out, 0);
    tick();
    check("final_empty_vld", bus.win_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
